// File: rtl/antirrebote.sv
// Push-button debouncer: a two-flop synchronizer feeds a four-state qualifier.
// A new level is accepted only after CICLOS consecutive stable samples.
module antirrebote #(
  parameter int unsigned CICLOS = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic nivel,
  output logic pulso_sube,
  output logic pulso_baja
);

  localparam int unsigned     CW       = $clog2(CICLOS + 1);
  localparam logic [CW-1:0]   CNT_ULT  = CW'(CICLOS - 1);
  localparam logic [CW-1:0]   CNT_UNO  = CW'(1);

  typedef enum logic [1:0] {
    ESTABLE_BAJO,
    CONTANDO_SUBIDA,
    ESTABLE_ALTO,
    CONTANDO_BAJADA
  } estado_t;

  logic          sinc0_q, sinc1_q;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nivel_q, nivel_d;
  logic          sube_q, sube_d;
  logic          baja_q, baja_d;

  logic muestra;
  assign muestra = sinc1_q;

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sinc0_q  <= 1'b0;
      sinc1_q  <= 1'b0;
      estado_q <= ESTABLE_BAJO;
      cnt_q    <= '0;
      nivel_q  <= 1'b0;
      sube_q   <= 1'b0;
      baja_q   <= 1'b0;
    end else begin
      sinc0_q  <= btn;
      sinc1_q  <= sinc0_q;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      nivel_q  <= nivel_d;
      sube_q   <= sube_d;
      baja_q   <= baja_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    nivel_d  = nivel_q;
    sube_d   = 1'b0;
    baja_d   = 1'b0;

    unique case (estado_q)
      ESTABLE_BAJO: begin
        if (muestra) begin
          estado_d = CONTANDO_SUBIDA;
          cnt_d    = CNT_UNO;
        end else begin
          cnt_d    = '0;
        end
      end

      CONTANDO_SUBIDA: begin
        if (!muestra) begin
          estado_d = ESTABLE_BAJO;
          cnt_d    = '0;
        end else if (cnt_q >= CNT_ULT) begin
          // Counter never passes CICLOS-1, so it cannot wrap.
          estado_d = ESTABLE_ALTO;
          cnt_d    = '0;
          nivel_d  = 1'b1;
          sube_d   = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_UNO;
        end
      end

      ESTABLE_ALTO: begin
        if (!muestra) begin
          estado_d = CONTANDO_BAJADA;
          cnt_d    = CNT_UNO;
        end else begin
          cnt_d    = '0;
        end
      end

      CONTANDO_BAJADA: begin
        if (muestra) begin
          estado_d = ESTABLE_ALTO;
          cnt_d    = '0;
        end else if (cnt_q >= CNT_ULT) begin
          estado_d = ESTABLE_BAJO;
          cnt_d    = '0;
          nivel_d  = 1'b0;
          baja_d   = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_UNO;
        end
      end

      default: begin
        estado_d = ESTABLE_BAJO;
        cnt_d    = '0;
      end
    endcase
  end

  assign nivel      = nivel_q;
  assign pulso_sube = sube_q;
  assign pulso_baja = baja_q;

endmodule
